// File: rtl/alu_operand_stage.sv
// Operand-issue stage feeding alu32: register file with write-through bypass,
// per-register busy scoreboard, and a one-entry valid/ready output register.
module alu_operand_stage #(
    parameter int WIDTH = 32,
    parameter int NREG  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [4:0]       rd,
    input  logic             rd_we,
    input  logic             use_imm,
    input  logic [WIDTH-1:0] imm,
    input  logic [3:0]       alucontrol_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] srca,
    output logic [WIDTH-1:0] srcb,
    output logic [3:0]       alucontrol,
    output logic [4:0]       shamt,
    output logic [4:0]       rd_out,
    input  logic             wb_en,
    input  logic [4:0]       wb_addr,
    input  logic [WIDTH-1:0] wb_data
);

    // Handshake: an instruction moves in when in_valid && in_ready, and out when
    // out_valid && out_ready; both may happen on the same edge.
    logic [NREG-1:0][WIDTH-1:0] rf_q, rf_d;
    logic [NREG-1:0]            busy_q, busy_d;
    logic                       out_valid_q, out_valid_d;
    logic [WIDTH-1:0]           srca_q, srca_d, srcb_q, srcb_d;
    logic [3:0]                 alucontrol_q, alucontrol_d;
    logic [4:0]                 shamt_q, shamt_d, rd_out_q, rd_out_d;

    logic             hazard, accept;
    logic             wb_hit_rs1, wb_hit_rs2;
    logic [WIDTH-1:0] rs1_val, rs2_val, srcb_sel;

    always_comb begin
        wb_hit_rs1 = wb_en && (wb_addr == rs1);
        wb_hit_rs2 = wb_en && (wb_addr == rs2);

        rs1_val = '0;
        if (rs1 != 5'd0) rs1_val = wb_hit_rs1 ? wb_data : rf_q[rs1];
        rs2_val = '0;
        if (rs2 != 5'd0) rs2_val = wb_hit_rs2 ? wb_data : rf_q[rs2];
        srcb_sel = use_imm ? imm : rs2_val;

        // A writeback arriving this cycle resolves the hazard it would cause.
        hazard = ((rs1 != 5'd0) && busy_q[rs1] && !wb_hit_rs1) ||
                 (!use_imm && (rs2 != 5'd0) && busy_q[rs2] && !wb_hit_rs2);
        in_ready = !hazard && (!out_valid_q || out_ready);
        accept   = in_valid && in_ready;
    end

    always_comb begin
        rf_d = rf_q;
        if (wb_en && (wb_addr != 5'd0)) rf_d[wb_addr] = wb_data;

        // Clear before set so a same-cycle reissue of the register stays busy.
        busy_d = busy_q;
        if (wb_en) busy_d[wb_addr] = 1'b0;
        if (accept && rd_we && (rd != 5'd0)) busy_d[rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        srca_d       = srca_q;
        srcb_d       = srcb_q;
        alucontrol_d = alucontrol_q;
        shamt_d      = shamt_q;
        rd_out_d     = rd_out_q;
        if (accept) begin
            out_valid_d  = 1'b1;
            srca_d       = rs1_val;
            srcb_d       = srcb_sel;
            alucontrol_d = alucontrol_in;
            shamt_d      = srcb_sel[4:0];
            rd_out_d     = rd_we ? rd : 5'd0;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_q         <= '0;
            busy_q       <= '0;
            out_valid_q  <= 1'b0;
            srca_q       <= '0;
            srcb_q       <= '0;
            alucontrol_q <= '0;
            shamt_q      <= '0;
            rd_out_q     <= '0;
        end else begin
            rf_q         <= rf_d;
            busy_q       <= busy_d;
            out_valid_q  <= out_valid_d;
            srca_q       <= srca_d;
            srcb_q       <= srcb_d;
            alucontrol_q <= alucontrol_d;
            shamt_q      <= shamt_d;
            rd_out_q     <= rd_out_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign srca       = srca_q;
    assign srcb       = srcb_q;
    assign alucontrol = alucontrol_q;
    assign shamt      = shamt_q;
    assign rd_out     = rd_out_q;

endmodule
